commutator_n: RTL and testbench

COMMUTATOR_N -- requirements
Module: commutator_n

---
 rtl/commutator_n_pkg.sv | 17 +
 rtl/delay_line_en.sv | 40 ++++
 rtl/commutator_n.sv | 148 ++++++++++++++
 tb/tb_commutator_n.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/commutator_n_pkg.sv
// Shared parameter definitions for the commutator_n block.
//   NB_DEFAULT  : default element width in bits
//   lanes_legal : LANES must be a power of two in 2..8
//   stage_legal : STAGE (group length in beats) must be at least 1
package commutator_n_pkg;

  localparam int NB_DEFAULT = 32;

  function automatic bit lanes_legal(input int lanes);
    return (lanes == 2) || (lanes == 4) || (lanes == 8);
  endfunction

  function automatic bit stage_legal(input int stage);
    return stage >= 1;
  endfunction

endpackage

// File: rtl/delay_line_en.sv
// Enable-gated delay line: q is d delayed by DEPTH enabled clock edges.
// DEPTH=0 degenerates to a plain wire. Contents are not reset; the owner
// is responsible for never qualifying stale taps.
// Ports:
//   clk : clock, rising edge
//   en  : shift enable (one accepted beat)
//   d   : NB-bit input element
//   q   : NB-bit delayed element
module delay_line_en
  import commutator_n_pkg::*;
#(
  parameter int NB    = NB_DEFAULT,
  parameter int DEPTH = 1
) (
  input  logic          clk,
  input  logic          en,
  input  logic [NB-1:0] d,
  output logic [NB-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ctrl;
    assign unused_ctrl = clk ^ en;
    assign q = d;
  end else begin : g_shift
    logic [NB-1:0] tap_q [DEPTH];

    always_ff @(posedge clk) begin
      if (en) begin
        tap_q[0] <= d;
        for (int i = 1; i < DEPTH; i++) begin
          tap_q[i] <= tap_q[i-1];
        end
      end
    end

    assign q = tap_q[DEPTH-1];
  end

endmodule

// File: rtl/commutator_n.sv
// Streaming LANES x LANES block transpose (commutator) with a bypass mode.
// A block is LANES groups of STAGE beats. In transpose mode output group g,
// offset o, lane j carries input group j, offset o, lane g of the same block,
// with a fixed latency of L=(LANES-1)*STAGE accepted beats. In bypass mode
// the output is the previous accepted beat, unchanged.
// Structure: input lane l is skewed by l*STAGE beats, a combinational
// rotation selected by the current group index swaps lanes, and output
// lane j is deskewed by (LANES-1-j)*STAGE beats, so every path totals L.
// Ports:
//   clk, reset_n : clock (rising edge), asynchronous active-low reset
//   start        : synchronous block restart; captures bypass
//   bypass       : mode request, sampled only with start
//   in_valid     : accepted-beat qualifier; all state advances only on it
//   in_data      : LANES packed NB-bit elements, lane l at [NB*l +: NB]
//   out_valid    : registered output qualifier
//   out_data     : registered output, same packing; holds when not valid
//   block_done   : with out_valid on the last beat of each output block
//   busy         : priming in progress (0 < primed beats < L)
module commutator_n
  import commutator_n_pkg::*;
#(
  parameter int NB    = NB_DEFAULT,
  parameter int LANES = 4,
  parameter int STAGE = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                bypass,
  input  logic                in_valid,
  input  logic [NB*LANES-1:0] in_data,
  output logic                out_valid,
  output logic [NB*LANES-1:0] out_data,
  output logic                block_done,
  output logic                busy
);

  localparam int BLK  = LANES * STAGE;
  localparam int CW   = $clog2(BLK);
  localparam int SELW = $clog2(LANES);
  localparam int L    = (LANES - 1) * STAGE;

  localparam logic [CW-1:0] BLK_LAST   = CW'(BLK - 1);
  localparam logic [CW-1:0] L_CNT      = CW'(L);
  // Output beat BLK-1 of a block appears while input beat (BLK-1+L) mod BLK,
  // i.e. L-1, is being accepted.
  localparam logic [CW-1:0] DONE_XPOSE = CW'(L - 1);

  if (!lanes_legal(LANES) || !stage_legal(STAGE)) begin : g_illegal
    $fatal(1, "commutator_n: LANES must be 2, 4 or 8 and STAGE must be >= 1");
  end

  logic [CW-1:0]       beat_q, beat_d;
  logic [CW-1:0]       prime_q, prime_d;
  logic                bypass_q, bypass_d;
  logic                out_valid_q, out_valid_d;
  logic                block_done_q, block_done_d;
  logic [NB*LANES-1:0] out_data_q, out_data_d;

  logic [CW-1:0]       beat_cur;
  logic [CW-1:0]       prime_cur;
  logic                mode_cur;
  logic [SELW-1:0]     grp;

  logic [NB-1:0]       lane_in   [LANES];
  logic [NB-1:0]       lane_skew [LANES];
  logic [NB-1:0]       lane_rot  [LANES];
  logic [NB-1:0]       lane_out  [LANES];
  logic [NB*LANES-1:0] xpose_data;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_in[l] = in_data[NB*l +: NB];

    delay_line_en #(.NB(NB), .DEPTH(l * STAGE)) u_skew (
      .clk (clk),
      .en  (in_valid),
      .d   (lane_in[l]),
      .q   (lane_skew[l])
    );

    // Output lane l picks skewed input lane (grp - l) mod LANES; the
    // subtraction wraps naturally because LANES is a power of two.
    assign lane_rot[l] = lane_skew[grp - SELW'(l)];

    delay_line_en #(.NB(NB), .DEPTH((LANES - 1 - l) * STAGE)) u_deskew (
      .clk (clk),
      .en  (in_valid),
      .d   (lane_rot[l]),
      .q   (lane_out[l])
    );

    assign xpose_data[NB*l +: NB] = lane_out[l];
  end

  always_comb begin
    // A start beat is beat 0 of a fresh block and uses the newly requested mode.
    beat_cur     = start ? '0 : beat_q;
    prime_cur    = start ? '0 : prime_q;
    mode_cur     = start ? bypass : bypass_q;
    grp          = SELW'(beat_cur / CW'(STAGE));

    beat_d       = beat_cur;
    prime_d      = prime_cur;
    bypass_d     = mode_cur;
    out_valid_d  = 1'b0;
    block_done_d = 1'b0;
    out_data_d   = out_data_q;

    if (in_valid) begin
      beat_d  = (beat_cur == BLK_LAST) ? '0 : beat_cur + CW'(1);
      prime_d = (prime_cur == L_CNT) ? L_CNT : prime_cur + CW'(1);
      if (mode_cur) begin
        out_valid_d  = 1'b1;
        out_data_d   = in_data;
        block_done_d = (beat_cur == BLK_LAST);
      end else if (prime_cur == L_CNT) begin
        out_valid_d  = 1'b1;
        out_data_d   = xpose_data;
        block_done_d = (beat_cur == DONE_XPOSE);
      end
    end
  end

  // Output register stage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat_q       <= '0;
      prime_q      <= '0;
      bypass_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      block_done_q <= 1'b0;
      out_data_q   <= '0;
    end else begin
      beat_q       <= beat_d;
      prime_q      <= prime_d;
      bypass_q     <= bypass_d;
      out_valid_q  <= out_valid_d;
      block_done_q <= block_done_d;
      out_data_q   <= out_data_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign block_done = block_done_q;
  assign busy       = (prime_q != '0) && (prime_q < L_CNT);

endmodule

// File: tb/tb_commutator_n.sv
// Bench for commutator_n: three configurations driven by one shared control
// stream and compared every cycle against a block-level transpose model.
module tb_commutator_n;

  localparam int NC = 3;
  localparam int L0 = 4, S0 = 1, N0 = 16;
  localparam int L1 = 4, S1 = 2, N1 = 32;
  localparam int L2 = 8, S2 = 3, N2 = 16;
  localparam int CL [NC] = '{L0, L1, L2};
  localparam int CS [NC] = '{S0, S1, S2};
  localparam int CN [NC] = '{N0, N1, N2};
  localparam int HMAX = 2048;
  localparam int K_RAND = 0, K_PAT = 1, K_FILL = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic bypass = 1'b0;
  logic in_valid = 1'b0;
  logic [127:0] din [NC];
  logic ov [NC];
  logic bd [NC];
  logic bz [NC];
  logic [L0*N0-1:0] od0;
  logic [L1*N1-1:0] od1;
  logic [L2*N2-1:0] od2;

  always #5 clk = ~clk;

  commutator_n #(.NB(N0), .LANES(L0), .STAGE(S0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .start(start), .bypass(bypass),
    .in_valid(in_valid), .in_data(din[0][L0*N0-1:0]),
    .out_valid(ov[0]), .out_data(od0), .block_done(bd[0]), .busy(bz[0]));

  commutator_n #(.NB(N1), .LANES(L1), .STAGE(S1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start), .bypass(bypass),
    .in_valid(in_valid), .in_data(din[1][L1*N1-1:0]),
    .out_valid(ov[1]), .out_data(od1), .block_done(bd[1]), .busy(bz[1]));

  commutator_n #(.NB(N2), .LANES(L2), .STAGE(S2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .start(start), .bypass(bypass),
    .in_valid(in_valid), .in_data(din[2][L2*N2-1:0]),
    .out_valid(ov[2]), .out_data(od2), .block_done(bd[2]), .busy(bz[2]));

  // Reference model state: accepted beats since the last start/reset.
  logic [127:0] hist [NC][HMAX];
  int           hcnt [NC];
  bit           mode [NC];
  bit           e_valid [NC];
  bit           e_done [NC];
  logic [127:0] e_data [NC];
  int           pcount;
  int           n_checks = 0;
  int           n_errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] lmask(input int nb);
    return (128'd1 << nb) - 128'd1;
  endfunction

  function automatic logic [127:0] lane_get(input logic [127:0] w, input int nb, input int l);
    return (w >> (nb * l)) & lmask(nb);
  endfunction

  function automatic logic [127:0] get_out(input int c);
    case (c)
      0:       return 128'(od0);
      1:       return 128'(od1);
      default: return 128'(od2);
    endcase
  endfunction

  // Group g, offset o, lane l of block blk carries 1000*blk + 100*o + 10*g + l.
  function automatic logic [127:0] pattern(input int c, input int p);
    int blen, blk, idx, g, o;
    logic [127:0] w;
    blen = CL[c] * CS[c];
    blk = p / blen;
    idx = p % blen;
    g = idx / CS[c];
    o = idx % CS[c];
    w = '0;
    for (int l = 0; l < CL[c]; l++)
      w |= (128'(1000 * blk + 100 * o + 10 * g + l) & lmask(CN[c])) << (CN[c] * l);
    return w;
  endfunction

  function automatic logic [127:0] fill(input int c, input logic [31:0] v);
    logic [127:0] w;
    w = '0;
    for (int l = 0; l < CL[c]; l++)
      w |= (128'(v) & lmask(CN[c])) << (CN[c] * l);
    return w;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      hcnt[c] = 0;
      mode[c] = 1'b0;
      e_valid[c] = 1'b0;
      e_done[c] = 1'b0;
      e_data[c] = '0;
    end
  endtask

  task automatic model_edge();
    for (int c = 0; c < NC; c++) begin
      int blen, lat, k, n, b, idx, g, o;
      logic [127:0] w;
      blen = CL[c] * CS[c];
      lat = (CL[c] - 1) * CS[c];
      if (start) begin
        hcnt[c] = 0;
        mode[c] = bypass;
      end
      e_valid[c] = 1'b0;
      e_done[c] = 1'b0;
      if (in_valid) begin
        if (hcnt[c] >= HMAX) begin
          $display("FAIL model history overflow: got %0d beats, limit %0d", hcnt[c], HMAX);
          $fatal(1);
        end
        k = hcnt[c];
        hist[c][k] = din[c];
        hcnt[c]++;
        if (mode[c]) begin
          e_valid[c] = 1'b1;
          e_data[c] = din[c];
          e_done[c] = ((k % blen) == blen - 1);
        end else if (k >= lat) begin
          n = k - lat;
          b = n / blen;
          idx = n % blen;
          g = idx / CS[c];
          o = idx % CS[c];
          w = '0;
          for (int j = 0; j < CL[c]; j++)
            w |= lane_get(hist[c][b * blen + j * CS[c] + o], CN[c], g) << (CN[c] * j);
          e_valid[c] = 1'b1;
          e_data[c] = w;
          e_done[c] = (idx == blen - 1);
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int c = 0; c < NC; c++) begin
      int lat;
      lat = (CL[c] - 1) * CS[c];
      chk($sformatf("cfg%0d out_valid", c), 128'(ov[c]), 128'(e_valid[c]));
      chk($sformatf("cfg%0d block_done", c), 128'(bd[c]), 128'(e_done[c]));
      chk($sformatf("cfg%0d busy", c), 128'(bz[c]), 128'(hcnt[c] > 0 && hcnt[c] < lat));
      chk($sformatf("cfg%0d out_data", c), get_out(c), e_data[c]);
    end
  endtask

  task automatic step(input logic st, input logic byp, input logic iv,
                      input int kind, input logic [31:0] fillv);
    start = st;
    bypass = byp;
    in_valid = iv;
    if (st) pcount = 0;
    for (int c = 0; c < NC; c++) begin
      case (kind)
        K_PAT:   din[c] = pattern(c, pcount);
        K_FILL:  din[c] = fill(c, fillv);
        default: din[c] = {$urandom(), $urandom(), $urandom(), $urandom()}
                          & lmask(CN[c] * CL[c]);
      endcase
    end
    if (iv) pcount++;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic pulse_reset();
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int done_cnt;
    pcount = 0;
    for (int c = 0; c < NC; c++) din[c] = '0;
    model_reset();

    // Reset state
    @(posedge clk);
    #1;
    compare_all();
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Continuous pattern, small transpose with explicit first row
    for (int i = 0; i < 48; i++) begin
      step(i == 0, 1'b0, 1'b1, K_PAT, 0);
      if (i == 2) chk("req021 priming", 128'(ov[0]), 128'd0);
      if (i == 3) chk("req021 row0", get_out(0), 128'h001E_0014_000A_0000);
      if (i == 6) chk("req021 block_done", 128'(bd[0]), 128'd1);
    end

    // in_valid toggling
    for (int i = 0; i < 60; i++) begin
      step(i == 0, 1'b0, (i % 2) == 0, K_PAT, 0);
      if ((i % 2) == 1) chk("req022 idle", 128'(ov[1]), 128'd0);
    end

    // Bypass: beats A, B, then bypass request dropped without start
    step(1'b1, 1'b1, 1'b1, K_FILL, 32'hA);
    chk("req023 beatA", get_out(1), 128'h0000000A_0000000A_0000000A_0000000A);
    step(1'b0, 1'b1, 1'b1, K_FILL, 32'hB);
    chk("req023 beatB", get_out(1), 128'h0000000B_0000000B_0000000B_0000000B);
    step(1'b0, 1'b0, 1'b1, K_RAND, 0);
    chk("req023 bypass held", 128'(ov[1]), 128'd1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'(i % 2), 1'b1, K_RAND, 0);

    // Restart mid-block (block 1, beat 5 of the LANES=4/STAGE=2 instance)
    step(1'b1, 1'b0, 1'b1, K_RAND, 0);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b1, K_RAND, 0);
    for (int i = 0; i < 40; i++) begin
      step(i == 0, 1'b0, 1'b1, K_RAND, 0);
      if (i < 6) chk("req024 no early valid", 128'(ov[1]), 128'd0);
      if (i == 6) chk("req024 first valid", 128'(ov[1]), 128'd1);
    end

    // Asynchronous reset mid-stream
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1, K_RAND, 0);
    pulse_reset();
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 1'b0, 1'b1, K_RAND, 0);
      if (i < 6) chk("req025 no early valid", 128'(ov[1]), 128'd0);
      if (i == 6) chk("req025 first valid", 128'(ov[1]), 128'd1);
    end

    // Four back-to-back blocks on the LANES=8/STAGE=3 instance
    done_cnt = 0;
    for (int i = 0; i < 4 * L2 * S2 + (L2 - 1) * S2; i++) begin
      step(i == 0, 1'b0, 1'b1, K_PAT, 0);
      done_cnt += int'(bd[2]);
    end
    chk("req026 block_done count", 128'(done_cnt), 128'd4);

    // Randomized traffic with occasional restarts and mode changes
    for (int i = 0; i < 400; i++) begin
      step((i == 0) || ($urandom_range(0, 99) < 3), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) < 7), K_RAND, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
